// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares one synchronous-read ROM port (1-cycle read latency) between the
//   CPU fetch path and the graphics DMA engine. One read is issued per cycle.
//   The owner of each read is carried alongside it, so the returned data goes
//   back to the requester that issued it.
//   Optional feature macro: ROM_ARB_FAIR_EN enables a CPU starvation guard.
//   With it, the CPU gets the port after DMA_BURST_MAX consecutive DMA grants.
//   Without it, DMA always has strict priority.

module rom_port_arbiter #(
  parameter int ADDR_W        = 14,
  parameter int DATA_W        = 8,
  parameter int DMA_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_gnt_o,
  output logic              cpu_valid_o,
  output logic [DATA_W-1:0] cpu_data_o,
  input  logic              dma_req_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  output logic              dma_gnt_o,
  output logic              dma_valid_o,
  output logic [DATA_W-1:0] dma_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_ce_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  logic              cpuForce;
  logic              cpuGnt;
  logic              dmaGnt;

  logic              tagValid_q, tagValid_d;
  logic              tagDma_q,   tagDma_d;
  logic              cpuValid_q, cpuValid_d;
  logic              dmaValid_q, dmaValid_d;
  logic [DATA_W-1:0] cpuData_q,  cpuData_d;
  logic [DATA_W-1:0] dmaData_q,  dmaData_d;

`ifdef ROM_ARB_FAIR_EN
  localparam int BurstW = $clog2(DMA_BURST_MAX + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(DMA_BURST_MAX);

  logic [BurstW-1:0] burst_q, burst_d;

  // The CPU wins the port once DMA has used up its burst allowance while the CPU waited.
  assign cpuForce = cpu_req_i && (burst_q == BurstMax);

  // The burst count tracks consecutive DMA wins over a waiting CPU. It restarts whenever the CPU is served or stops asking.
  always_comb begin
    burst_d = burst_q;
    if (cpuGnt || !cpu_req_i) begin
      burst_d = '0;
    end else if (dmaGnt && (burst_q != BurstMax)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign cpuForce = 1'b0;
`endif

  // Grant selection and address mux. DMA has priority unless the CPU is being forced through. Nothing is granted during reset.
  always_comb begin
    dmaGnt     = !rst && dma_req_i && !cpuForce;
    cpuGnt     = !rst && cpu_req_i && !dmaGnt;
    mem_addr_o = '0;
    if (dmaGnt) begin
      mem_addr_o = dma_addr_i;
    end else if (cpuGnt) begin
      mem_addr_o = cpu_addr_i;
    end
  end

  assign cpu_gnt_o = cpuGnt;
  assign dma_gnt_o = dmaGnt;
  assign mem_ce_o  = cpuGnt | dmaGnt;

  // Next state of the two pipeline stages.
  // The tag stage records who owns the read issued this cycle.
  // The return stage steers the ROM data of the previous read to its owner, and each data register keeps its last value between reads.
  always_comb begin
    tagValid_d = cpuGnt | dmaGnt;
    tagDma_d   = dmaGnt;
    cpuValid_d = tagValid_q && !tagDma_q;
    dmaValid_d = tagValid_q && tagDma_q;
    cpuData_d  = cpuData_q;
    dmaData_d  = dmaData_q;
    if (cpuValid_d) begin
      cpuData_d = mem_data_i;
    end
    if (dmaValid_d) begin
      dmaData_d = mem_data_i;
    end
  end

  // Pipeline registers. Reset discards any read that is still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tagValid_q <= 1'b0;
      tagDma_q   <= 1'b0;
      cpuValid_q <= 1'b0;
      dmaValid_q <= 1'b0;
      cpuData_q  <= '0;
      dmaData_q  <= '0;
    end else begin
      tagValid_q <= tagValid_d;
      tagDma_q   <= tagDma_d;
      cpuValid_q <= cpuValid_d;
      dmaValid_q <= dmaValid_d;
      cpuData_q  <= cpuData_d;
      dmaData_q  <= dmaData_d;
    end
  end

  assign cpu_valid_o = cpuValid_q;
  assign dma_valid_o = dmaValid_q;
  assign cpu_data_o  = cpuData_q;
  assign dma_data_o  = dmaData_q;

endmodule
